// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the fifo_flags buffer:
//   - FIFO_MODE_STD / FIFO_MODE_FWFT : values for the fifo_flags 'fwft' parameter
//   - log2()                         : ceiling log2, sizes pointers and count
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;  // registered read, 1-cycle latency
  localparam int FIFO_MODE_FWFT = 1;  // first-word fall-through

  // Ceiling log2 evaluated at elaboration. log2(8) = 3, log2(2) = 1.
  function automatic int log2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Flop-based storage array for fifo_flags: one synchronous write port and one
// asynchronous (combinational) read port.
//
// Ports:
//   clk    in   clock, write happens on the rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  read data, combinational from raddr
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int data_width = 32,
  parameter  int fifo_depth = 8,
  localparam int addr_width = log2(fifo_depth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem_q [fifo_depth];

  // NOTE: the array has no reset on purpose; occupancy is tracked by the
  // pointers and count, so stale contents are never observable, and leaving
  // the reset off keeps the array mappable to plain flops or distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/fifo_flags.sv
// -----------------------------------------------------------------------------
// fifo_flags
// Single-clock FIFO with occupancy count and programmable almost-full /
// almost-empty flags. Read mode is selected by the 'fwft' parameter:
//   FIFO_MODE_STD  : dout registered on an accepted read (1-cycle latency)
//   FIFO_MODE_FWFT : dout shows the head entry combinationally while not empty
//
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// error flags with a clear input.
//
// Ports:
//   clk           in   clock, all state on the rising edge
//   rst           in   asynchronous active-high reset
//   wr_en         in   write request (dropped while full)
//   din           in   write data
//   full          out  count == fifo_depth
//   almost_full   out  count >= almost_full_thresh
//   rd_en         in   read / pop request (ignored while empty)
//   dout          out  read data
//   empty         out  count == 0
//   almost_empty  out  count <= almost_empty_thresh
//   count         out  current occupancy
//   err_clr       in   (FIFO_ERR_FLAGS_EN) clears overflow and underflow
//   overflow      out  (FIFO_ERR_FLAGS_EN) sticky: wr_en seen while full
//   underflow     out  (FIFO_ERR_FLAGS_EN) sticky: rd_en seen while empty
// -----------------------------------------------------------------------------
module fifo_flags
  import fifo_pkg::*;
#(
  parameter  int data_width          = 32,
  parameter  int fifo_depth          = 8,
  parameter  int almost_full_thresh  = 6,
  parameter  int almost_empty_thresh = 1,
  parameter  int fwft                = FIFO_MODE_STD,
  localparam int addr_width          = log2(fifo_depth),
  localparam int count_width         = log2(fifo_depth) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [data_width-1:0]  din,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [data_width-1:0]  dout,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [count_width-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  typedef logic [addr_width-1:0]  ptr_t;
  typedef logic [count_width-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(fifo_depth);
  localparam cnt_t AF_C    = cnt_t'(almost_full_thresh);
  localparam cnt_t AE_C    = cnt_t'(almost_empty_thresh);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // ---------------------------------------------------------------------------
  if (data_width < 1) begin : g_bad_width
    $error("fifo_flags: data_width must be >= 1");
  end
  if (fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_depth
    $error("fifo_flags: fifo_depth must be a power of 2 and >= 2");
  end
  if (almost_full_thresh < 1 || almost_full_thresh > fifo_depth) begin : g_bad_af
    $error("fifo_flags: almost_full_thresh must be in 1..fifo_depth");
  end
  if (almost_empty_thresh < 0 || almost_empty_thresh > fifo_depth - 1) begin : g_bad_ae
    $error("fifo_flags: almost_empty_thresh must be in 0..fifo_depth-1");
  end
  if (almost_full_thresh <= almost_empty_thresh) begin : g_bad_thresh
    $error("fifo_flags: almost_full_thresh must exceed almost_empty_thresh");
  end
  if (fwft != FIFO_MODE_STD && fwft != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_flags: fwft must be FIFO_MODE_STD or FIFO_MODE_FWFT");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ptr_t wptr_q, wptr_d;
  ptr_t rptr_q, rptr_d;
  cnt_t count_q, count_d;

  logic                  wr_ok;
  logic                  rd_ok;
  logic [data_width-1:0] rdata;

  // Flags depend only on the count register, never on this cycle's requests.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A write while full is dropped even if a read frees a slot this cycle.
  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = wptr_q + ptr_t'(1);  // wraps naturally at fifo_depth
    end
    if (rd_ok) begin
      rptr_d = rptr_q + ptr_t'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order within the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  fifo_mem #(
    .data_width (data_width),
    .fifo_depth (fifo_depth)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdata (din),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  // ---------------------------------------------------------------------------
  // Read data path
  // ---------------------------------------------------------------------------
  if (fwft == FIFO_MODE_FWFT) begin : g_fwft
    // Head entry is visible while not empty; forced to zero when empty so the
    // output is clean out of reset.
    assign dout = empty ? '0 : rdata;
  end else begin : g_std
    logic [data_width-1:0] dout_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_ok) begin
        dout_q <= rdata;
      end
    end

    assign dout = dout_q;
  end

  // ---------------------------------------------------------------------------
  // Optional sticky error flags
  // ---------------------------------------------------------------------------
`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  // err_clr wins over a set in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (err_clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule : fifo_flags

// File: tb/tb_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_fifo_flags
// Drives one standard-read and one FWFT instance of fifo_flags with the same
// directed stimulus. A queue-based model tracks the contents; a negedge
// process compares both instances against it every cycle, and directed steps
// add hand-computed literal expectations.
// Build with FIFO_ERR_FLAGS_EN defined to also exercise the error flags.
// -----------------------------------------------------------------------------
module tb_fifo_flags;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int AF_T  = 6;
  localparam int AE_T  = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic          rd_en;
  logic          err_clr;
  logic [DW-1:0] din;

  logic [DW-1:0] dout_s, dout_f;
  logic [CW-1:0] count_s, count_f;
  logic          full_s, full_f, af_s, af_f, empty_s, empty_f, ae_s, ae_f;
  logic          ovf_s, ovf_f, unf_s, unf_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_flags #(
    .data_width(DW), .fifo_depth(DEPTH), .almost_full_thresh(AF_T),
    .almost_empty_thresh(AE_T), .fwft(0)
  ) dut_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_s),
    .almost_full(af_s), .rd_en(rd_en), .dout(dout_s), .empty(empty_s),
    .almost_empty(ae_s), .count(count_s)
`ifdef FIFO_ERR_FLAGS_EN
    , .err_clr(err_clr), .overflow(ovf_s), .underflow(unf_s)
`endif
  );

  fifo_flags #(
    .data_width(DW), .fifo_depth(DEPTH), .almost_full_thresh(AF_T),
    .almost_empty_thresh(AE_T), .fwft(1)
  ) dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_f),
    .almost_full(af_f), .rd_en(rd_en), .dout(dout_f), .empty(empty_f),
    .almost_empty(ae_f), .count(count_f)
`ifdef FIFO_ERR_FLAGS_EN
    , .err_clr(err_clr), .overflow(ovf_f), .underflow(unf_f)
`endif
  );

`ifndef FIFO_ERR_FLAGS_EN
  assign ovf_s = 1'b0;
  assign ovf_f = 1'b0;
  assign unf_s = 1'b0;
  assign unf_f = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: contents as a queue, std-mode output as a variable.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_unf  = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    bit was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (wr_en && was_full)  m_ovf = 1'b1;
        if (rd_en && was_empty) m_unf = 1'b1;
      end
      if (rd_en && !was_empty) m_dout = mq.pop_front();
      if (wr_en && !was_full)  mq.push_back(din);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    int n;
    if (!rst) begin
      n = mq.size();
      check("cmp_count_s", 32'(count_s), n);
      check("cmp_count_f", 32'(count_f), n);
      check("cmp_empty_s", 32'(empty_s), 32'(n == 0));
      check("cmp_empty_f", 32'(empty_f), 32'(n == 0));
      check("cmp_full_s",  32'(full_s),  32'(n == DEPTH));
      check("cmp_full_f",  32'(full_f),  32'(n == DEPTH));
      check("cmp_af_s",    32'(af_s),    32'(n >= AF_T));
      check("cmp_af_f",    32'(af_f),    32'(n >= AF_T));
      check("cmp_ae_s",    32'(ae_s),    32'(n <= AE_T));
      check("cmp_ae_f",    32'(ae_f),    32'(n <= AE_T));
      check("cmp_dout_s",  dout_s, m_dout);
      if (n > 0) check("cmp_dout_f", dout_f, mq[0]);
`ifdef FIFO_ERR_FLAGS_EN
      check("cmp_ovf_s", 32'(ovf_s), 32'(m_ovf));
      check("cmp_ovf_f", 32'(ovf_f), 32'(m_ovf));
      check("cmp_unf_s", 32'(unf_s), 32'(m_unf));
      check("cmp_unf_f", 32'(unf_f), 32'(m_unf));
`endif
    end
  end

  // Drive one cycle of requests; returns 2 time units after the sampling edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] words [DEPTH];
  logic [DW-1:0] tail  [7];

  initial begin : stimulus
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0; err_clr = 1'b0;
    #22 rst = 1'b0;
    @(posedge clk); #2;

    // ---- Asynchronous reset mid-operation -----------------------------------
    step(1, 32'h1111_0001, 0);
    step(1, 32'h1111_0002, 0);
    step(1, 32'h1111_0003, 0);
    step(0, '0, 1);
    check("pre_rst_dout", dout_s, 32'h1111_0001);
    check("pre_rst_count", 32'(count_s), 2);
    wr_en = 1'b0; rd_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_count_s", 32'(count_s), 0);
    check("rst_count_f", 32'(count_f), 0);
    check("rst_empty",   32'(empty_s), 1);
    check("rst_full",    32'(full_s),  0);
    check("rst_ae",      32'(ae_s),    1);
    check("rst_af",      32'(af_s),    0);
    check("rst_dout",    dout_s,       32'h0);
    rst = 1'b0;
    step(0, '0, 0);

    // ---- Fill, one write every two cycles -----------------------------------
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = $urandom;
      step(1, words[i], 0);
      check("fill_count", 32'(count_s), i + 1);
      check("fill_af",    32'(af_s),    32'(i + 1 >= 6));
      check("fill_full",  32'(full_s),  32'(i == 7));
      step(0, '0, 0);
    end

    // ---- Writes while full are dropped ---------------------------------------
    for (int i = 0; i < 20; i++) begin
      step(1, 32'hBAD0_0000 + i, 0);
      check("ovr_count", 32'(count_s), 8);
    end

    // ---- Drain in order -------------------------------------------------------
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_head_f", dout_f, words[i]);
      step(0, '0, 1);
      check("drain_dout_s", dout_s, words[i]);
    end
    check("drain_empty_s", 32'(empty_s), 1);
    check("drain_empty_f", 32'(empty_f), 1);
    step(0, '0, 0);

    // ---- FWFT: head visible one edge after the write, no rd_en ---------------
    step(1, 32'hA5A5_A5A5, 0);
    check("fwft_dout",  dout_f,         32'hA5A5_A5A5);
    check("fwft_empty", 32'(empty_f),   0);
    step(0, '0, 1);
    check("fwft_pop_empty", 32'(empty_f), 1);
    check("fwft_pop_count", 32'(count_f), 0);
    check("std_pop_dout",   dout_s,       32'hA5A5_A5A5);
    step(0, '0, 0);

    // ---- Simultaneous read/write at count=4 ----------------------------------
    for (int i = 0; i < 4; i++) step(1, 32'h10 + i, 0);
    check("sim_count_pre", 32'(count_s), 4);
    for (int k = 0; k < 10; k++) begin
      step(1, 32'h100 + k, 1);
      check("sim_count", 32'(count_s), 4);
      check("sim_dout",  dout_s, (k < 4) ? 32'h10 + k : 32'h100 + k - 4);
    end

    // ---- Simultaneous at full: read taken, write dropped ---------------------
    for (int i = 0; i < 4; i++) step(1, 32'h200 + i, 0);
    check("full_count", 32'(count_s), 8);
    step(1, 32'h999, 1);
    check("full_rw_count", 32'(count_s), 7);
    check("full_rw_dout",  dout_s, 32'h106);
    tail = '{32'h107, 32'h108, 32'h109, 32'h200, 32'h201, 32'h202, 32'h203};
    for (int i = 0; i < 7; i++) begin
      step(0, '0, 1);
      check("tail_dout", dout_s, tail[i]);
    end

    // ---- Reads while empty are ignored ---------------------------------------
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1);
      check("udf_count", 32'(count_s), 0);
      check("udf_empty", 32'(empty_s), 1);
      check("udf_dout",  dout_s, 32'h203);
    end
    step(1, 32'h1234_5678, 0);
    check("udf_next_f", dout_f, 32'h1234_5678);
    step(0, '0, 1);
    check("udf_next_s", dout_s, 32'h1234_5678);
    step(0, '0, 0);

`ifdef FIFO_ERR_FLAGS_EN
    // ---- Sticky error flags ---------------------------------------------------
    check("err_unf_prior", 32'(unf_s), 1);
    err_clr = 1'b1;
    step(0, '0, 0);
    err_clr = 1'b0;
    check("err_clr_unf", 32'(unf_s), 0);
    for (int i = 0; i < DEPTH; i++) step(1, 32'h300 + i, 0);
    check("err_ovf_pre", 32'(ovf_s), 0);
    step(1, 32'h3FF, 0);
    check("err_ovf_s", 32'(ovf_s), 1);
    check("err_ovf_f", 32'(ovf_f), 1);
    for (int i = 0; i < 3; i++) step(0, '0, 0);
    check("err_ovf_sticky", 32'(ovf_s), 1);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1);
    step(0, '0, 1);
    check("err_unf_s", 32'(unf_s), 1);
    check("err_unf_f", 32'(unf_f), 1);
    // Clear with a same-cycle underflow: clear wins.
    err_clr = 1'b1;
    step(0, '0, 1);
    err_clr = 1'b0;
    check("err_clr_ovf", 32'(ovf_s), 0);
    check("err_clr_prio", 32'(unf_s), 0);
    step(0, '0, 0);
`endif

    step(0, '0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fifo_flags
